multicycle_control: RTL and testbench

- Moore-style FSM that sequences the shared multicycle RISC-V datapath: PC, IR, ALU, register file, unified memory and the immediate generator.
- Decodes the latched instruction, selects the immediate format (ImmSrc, types_pkg::instr_format) and drives the mux selects and write strobes.
- Stretches memory states on a ready handshake and traps on illegal opcode or memory timeout.
- Sits between the IR and the datapath, replacing the single-cycle combinational control unit.

---
 rtl/types_pkg.sv | 65 ++++++
 rtl/ctrl_decode.sv | 51 +++++
 rtl/multicycle_control.sv | 259 +++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared control types for the multicycle RISC-V core.
//   ctrl_state_t : FSM state encoding, exported on state_o for trace
//   alu_op_t     : ALU operation class handed to the ALU decoder
//   instr_format : immediate format selector for the sign extender
//   OP_*         : base opcodes recognised by the control unit
//   SRCA_/SRCB_/RES_/ADR_ : datapath mux select encodings
package types_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LUI,
    S_TRAP
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_FUNCT
  } alu_op_t;

  typedef enum logic [2:0] {
    Imm,
    Store,
    Branch,
    Jump,
    UpperImm
  } instr_format;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RD1   = 2'd2;

  localparam logic [1:0] SRCB_RD2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_DATA      = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;
  localparam logic [1:0] RES_IMM       = 2'd3;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder for the multicycle control FSM.
//   opcode     : instr[6:0]
//   funct3     : instr[14:12]
//   decodeNext : state to enter after DECODE (S_TRAP for unknown opcodes)
//   immSrc     : immediate format for the sign extender
//   opLegal    : opcode is one the control unit implements
//   branchOk   : funct3 names a supported branch (beq/bne only)
module ctrl_decode
  import types_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  output ctrl_state_t decodeNext,
  output instr_format immSrc,
  output logic        opLegal,
  output logic        branchOk
);

  always_comb begin
    decodeNext = S_TRAP;
    immSrc     = Imm;
    opLegal    = 1'b1;
    case (opcode)
      OP_LOAD:   decodeNext = S_MEMADR;
      OP_STORE: begin
        decodeNext = S_MEMADR;
        immSrc     = Store;
      end
      OP_R:      decodeNext = S_EXECR;
      OP_I:      decodeNext = S_EXECI;
      OP_BRANCH: begin
        decodeNext = S_BRANCH;
        immSrc     = Branch;
      end
      OP_JAL: begin
        decodeNext = S_JAL;
        immSrc     = Jump;
      end
      OP_JALR:   decodeNext = S_JALR;
      OP_LUI: begin
        decodeNext = S_LUI;
        immSrc     = UpperImm;
      end
      default:   opLegal = 1'b0;
    endcase
  end

  // Only beq (000) and bne (001) are handled; bit 0 selects the inversion.
  assign branchOk = (funct3[2:1] == 2'b00);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: a Moore FSM that sequences PC, IR, ALU,
// register file and the unified memory, with a ready handshake on memory
// states, a memory timeout and a sticky trap.
//   clk, rst           : clock, asynchronous active-high reset
//   instr              : IR contents (valid from DECODE on)
//   Zero               : ALU zero flag (used in BRANCH)
//   mem_ready          : memory completes the current access this cycle
//   MemRead, MemWrite  : memory request strobes
//   AdrSrc             : memory address select (PC / ALUOut)
//   IRWrite, PCWrite   : IR/OldPC load, PC load
//   RegWrite           : register file write enable
//   ALUSrcA, ALUSrcB   : ALU operand selects
//   ALUOp              : ALU operation class
//   ResultSrc          : result bus select
//   ImmSrc             : immediate format
//   trap               : sticky fault flag
//   state_o            : current state for trace
module multicycle_control
  import types_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 255,
  parameter int RESET_PC_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output alu_op_t     ALUOp,
  output logic [1:0]  ResultSrc,
  output instr_format ImmSrc,
  output logic        trap,
  output ctrl_state_t state_o
);

  localparam int TMO_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int HOLD_W = (RESET_PC_HOLD < 1) ? 1 : $clog2(RESET_PC_HOLD + 1);

  ctrl_state_t       state;
  logic [TMO_W-1:0]  tmoCnt;
  logic [HOLD_W-1:0] settleCnt;
  logic              linkFlag;
  logic              trapReg;

  ctrl_state_t decodeNext;
  instr_format decImmSrc;
  logic        opLegal;
  logic        branchOk;
  logic        settling;
  logic        inMemState;
  logic        tmoExpire;
  logic        unusedInstrBits;

  ctrl_decode u_decode (
    .opcode    (instr[6:0]),
    .funct3    (instr[14:12]),
    .decodeNext(decodeNext),
    .immSrc    (decImmSrc),
    .opLegal   (opLegal),
    .branchOk  (branchOk)
  );

  // Register/immediate fields are consumed by the datapath, not here.
  assign unusedInstrBits = ^{instr[31:15], instr[11:7]};

  // While settling after reset, FETCH issues no request, so mem_ready is
  // ignored and the timeout does not run.
  assign settling   = (settleCnt != '0);
  assign inMemState = ((state == S_FETCH) && !settling) ||
                      (state == S_MEMREAD) || (state == S_MEMWRITE);
  // Last permitted waiting cycle without ready; a ready in this cycle wins.
  assign tmoExpire  = inMemState && !mem_ready &&
                      (tmoCnt == TMO_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      settleCnt <= HOLD_W'(RESET_PC_HOLD);
      tmoCnt    <= '0;
      linkFlag  <= 1'b0;
      trapReg   <= 1'b0;
    end else begin
      tmoCnt <= '0;
      case (state)
        S_FETCH: begin
          if (settling) begin
            settleCnt <= settleCnt - HOLD_W'(1);
          end else if (mem_ready) begin
            state <= S_DECODE;
          end else if (tmoExpire) begin
            state   <= S_TRAP;
            trapReg <= 1'b1;
          end else begin
            tmoCnt <= tmoCnt + TMO_W'(1);
          end
        end
        S_DECODE: begin
          state <= decodeNext;
          if (!opLegal) trapReg <= 1'b1;
        end
        S_MEMADR:  state <= instr[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD: begin
          if (mem_ready) begin
            state <= S_MEMWB;
          end else if (tmoExpire) begin
            state   <= S_TRAP;
            trapReg <= 1'b1;
          end else begin
            tmoCnt <= tmoCnt + TMO_W'(1);
          end
        end
        S_MEMWB:   state <= S_FETCH;
        S_MEMWRITE: begin
          if (mem_ready) begin
            state <= S_FETCH;
          end else if (tmoExpire) begin
            state   <= S_TRAP;
            trapReg <= 1'b1;
          end else begin
            tmoCnt <= tmoCnt + TMO_W'(1);
          end
        end
        S_EXECR:   state <= S_ALUWB;
        S_EXECI:   state <= S_ALUWB;
        S_ALUWB: begin
          state    <= S_FETCH;
          linkFlag <= 1'b0;
        end
        S_BRANCH: begin
          if (branchOk) begin
            state <= S_FETCH;
          end else begin
            state   <= S_TRAP;
            trapReg <= 1'b1;
          end
        end
        // The following ALUWB writes the link value OldPC+4.
        S_JAL: begin
          state    <= S_ALUWB;
          linkFlag <= 1'b1;
        end
        S_JALR:    state <= S_JAL;
        S_LUI:     state <= S_FETCH;
        S_TRAP:    state <= S_TRAP;
        default: begin
          state   <= S_TRAP;
          trapReg <= 1'b1;
        end
      endcase
    end
  end

  // Output decode; rst gates everything so nothing can strobe while it is high.
  always_comb begin
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = ADR_PC;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ALUOp     = ALU_ADD;
    ResultSrc = RES_ALUOUT;
    ImmSrc    = Imm;
    if (!rst) begin
      if ((state != S_FETCH) && (state != S_TRAP)) ImmSrc = decImmSrc;
      case (state)
        S_FETCH: begin
          AdrSrc    = ADR_PC;
          MemRead   = !settling;
          ALUSrcA   = SRCA_PC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
          if (!settling && mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMREAD: begin
          AdrSrc  = ADR_ALUOUT;
          MemRead = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc   = ADR_ALUOUT;
          MemWrite = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_RD2;
          ALUOp   = ALU_FUNCT;
        end
        S_EXECI: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_FUNCT;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          if (linkFlag) begin
            // Keep OldPC+4 on the ALU so ALUResult carries the link value.
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
          end else begin
            ResultSrc = RES_ALUOUT;
          end
        end
        S_BRANCH: begin
          ALUSrcA   = SRCA_RD1;
          ALUSrcB   = SRCB_RD2;
          ALUOp     = ALU_SUB;
          ResultSrc = RES_ALUOUT;
          PCWrite   = branchOk && (Zero ^ instr[12]);
        end
        S_JAL: begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALUOUT;
          PCWrite   = 1'b1;
        end
        S_JALR: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
        end
        S_LUI: begin
          ResultSrc = RES_IMM;
          ImmSrc    = UpperImm;
          RegWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign trap    = trapReg;
  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a table of per-cycle vectors for
// the instruction sequences, plus hand-written reset/trap/timeout sequences.
module tb_multicycle_control;
  import types_pkg::*;

  localparam int MEM_TIMEOUT   = 4;
  localparam int RESET_PC_HOLD = 1;

  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_SW   = 32'h0050A623;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BRX  = 32'h0020A463;
  localparam logic [31:0] I_JAL  = 32'h0080006F;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'h00508193;
  localparam logic [31:0] I_JALR = 32'h000280E7;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, trap;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  alu_op_t     ALUOp;
  instr_format ImmSrc;
  ctrl_state_t state_o;

  multicycle_control #(
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .RESET_PC_HOLD(RESET_PC_HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .Zero     (Zero),
    .mem_ready(mem_ready),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .AdrSrc   (AdrSrc),
    .IRWrite  (IRWrite),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .ResultSrc(ResultSrc),
    .ImmSrc   (ImmSrc),
    .trap     (trap),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    ctrl_state_t st;
    logic        memRead;
    logic        memWrite;
    logic        adrSrc;
    logic        irWrite;
    logic        pcWrite;
    logic        regWrite;
    logic [1:0]  srcA;
    logic [1:0]  srcB;
    alu_op_t     aluOp;
    logic [1:0]  resSrc;
    instr_format immSrc;
    logic        trap;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        ready;
    obs_t        exp;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t vq[$];

  // strb = {MemRead, MemWrite, IRWrite, PCWrite, RegWrite}
  function automatic obs_t mk(ctrl_state_t s, logic [4:0] strb, int adr, int a,
                              int b, alu_op_t op, int res, instr_format imm, int tr);
    obs_t o;
    o.st       = s;
    o.memRead  = strb[4];
    o.memWrite = strb[3];
    o.adrSrc   = 1'(adr);
    o.irWrite  = strb[2];
    o.pcWrite  = strb[1];
    o.regWrite = strb[0];
    o.srcA     = 2'(a);
    o.srcB     = 2'(b);
    o.aluOp    = op;
    o.resSrc   = 2'(res);
    o.immSrc   = imm;
    o.trap     = 1'(tr);
    return o;
  endfunction

  function automatic obs_t rstObs();
    return mk(S_FETCH, 5'b00000, 0, 0, 0, ALU_ADD, 0, Imm, 0);
  endfunction
  function automatic obs_t settleObs();
    return mk(S_FETCH, 5'b00000, 0, 0, 2, ALU_ADD, 2, Imm, 0);
  endfunction
  function automatic obs_t fetchHit();
    return mk(S_FETCH, 5'b10110, 0, 0, 2, ALU_ADD, 2, Imm, 0);
  endfunction
  function automatic obs_t fetchWait();
    return mk(S_FETCH, 5'b10000, 0, 0, 2, ALU_ADD, 2, Imm, 0);
  endfunction
  function automatic obs_t dec(instr_format imm);
    return mk(S_DECODE, 5'b00000, 0, 1, 1, ALU_ADD, 0, imm, 0);
  endfunction
  function automatic obs_t trapObs();
    return mk(S_TRAP, 5'b00000, 0, 0, 0, ALU_ADD, 0, Imm, 1);
  endfunction
  function automatic obs_t memWr();
    return mk(S_MEMWRITE, 5'b01000, 1, 0, 0, ALU_ADD, 0, Store, 0);
  endfunction

  function automatic obs_t actual();
    obs_t o;
    o.st       = state_o;
    o.memRead  = MemRead;
    o.memWrite = MemWrite;
    o.adrSrc   = AdrSrc;
    o.irWrite  = IRWrite;
    o.pcWrite  = PCWrite;
    o.regWrite = RegWrite;
    o.srcA     = ALUSrcA;
    o.srcB     = ALUSrcB;
    o.aluOp    = ALUOp;
    o.resSrc   = ResultSrc;
    o.immSrc   = ImmSrc;
    o.trap     = trap;
    return o;
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = actual();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (state got=%0d exp=%0d)",
               name, act, exp, act.st, exp.st);
    end
  endtask

  // Called just after a rising edge; checks mid-cycle, returns after the next edge.
  task automatic step(input logic [31:0] i, input logic z, input logic r,
                      input obs_t e, input string name);
    instr     = i;
    Zero      = z;
    mem_ready = r;
    @(negedge clk);
    check(name, e);
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset(input string name);
    #2 rst = 1'b1;
    #1 check(name, rstObs());
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic addV(input logic [31:0] i, input logic z, input logic r, input obs_t e);
    vec_t v;
    v.instr = i;
    v.zero  = z;
    v.ready = r;
    v.exp   = e;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // lw: ready arrives during the settle cycle and must be ignored
    addV(I_LW,  0, 1, settleObs());
    addV(I_LW,  0, 1, fetchHit());
    addV(I_LW,  0, 1, dec(Imm));
    addV(I_LW,  0, 1, mk(S_MEMADR,  5'b00000, 0, 2, 1, ALU_ADD, 0, Imm, 0));
    addV(I_LW,  0, 1, mk(S_MEMREAD, 5'b10000, 1, 0, 0, ALU_ADD, 0, Imm, 0));
    addV(I_LW,  0, 1, mk(S_MEMWB,   5'b00001, 0, 0, 0, ALU_ADD, 1, Imm, 0));
    // sw with ready on the 4th MEMWRITE cycle (same cycle the timeout would fire)
    addV(I_SW,  0, 1, fetchHit());
    addV(I_SW,  0, 1, dec(Store));
    addV(I_SW,  0, 1, mk(S_MEMADR,  5'b00000, 0, 2, 1, ALU_ADD, 0, Store, 0));
    addV(I_SW,  0, 0, memWr());
    addV(I_SW,  0, 0, memWr());
    addV(I_SW,  0, 0, memWr());
    addV(I_SW,  0, 1, memWr());
    // beq taken / not taken
    addV(I_BEQ, 0, 1, fetchHit());
    addV(I_BEQ, 0, 1, dec(Branch));
    addV(I_BEQ, 1, 1, mk(S_BRANCH, 5'b00010, 0, 2, 0, ALU_SUB, 0, Branch, 0));
    addV(I_BEQ, 0, 1, fetchHit());
    addV(I_BEQ, 0, 1, dec(Branch));
    addV(I_BEQ, 0, 1, mk(S_BRANCH, 5'b00000, 0, 2, 0, ALU_SUB, 0, Branch, 0));
    // bne inverted
    addV(I_BNE, 0, 1, fetchHit());
    addV(I_BNE, 0, 1, dec(Branch));
    addV(I_BNE, 1, 1, mk(S_BRANCH, 5'b00000, 0, 2, 0, ALU_SUB, 0, Branch, 0));
    addV(I_BNE, 0, 1, fetchHit());
    addV(I_BNE, 0, 1, dec(Branch));
    addV(I_BNE, 0, 1, mk(S_BRANCH, 5'b00010, 0, 2, 0, ALU_SUB, 0, Branch, 0));
    // jal: PC write, then link write from ALUResult
    addV(I_JAL, 0, 1, fetchHit());
    addV(I_JAL, 0, 1, dec(Jump));
    addV(I_JAL, 0, 1, mk(S_JAL,   5'b00010, 0, 1, 2, ALU_ADD, 0, Jump, 0));
    addV(I_JAL, 0, 1, mk(S_ALUWB, 5'b00001, 0, 1, 2, ALU_ADD, 2, Jump, 0));
    // lui
    addV(I_LUI, 0, 1, fetchHit());
    addV(I_LUI, 0, 1, dec(UpperImm));
    addV(I_LUI, 0, 1, mk(S_LUI, 5'b00001, 0, 0, 0, ALU_ADD, 3, UpperImm, 0));
    // R-type: writeback must use ALUOut again (link flag cleared)
    addV(I_ADD, 0, 1, fetchHit());
    addV(I_ADD, 0, 1, dec(Imm));
    addV(I_ADD, 0, 1, mk(S_EXECR, 5'b00000, 0, 2, 0, ALU_FUNCT, 0, Imm, 0));
    addV(I_ADD, 0, 1, mk(S_ALUWB, 5'b00001, 0, 0, 0, ALU_ADD, 0, Imm, 0));
    // I-type ALU
    addV(I_ADDI, 0, 1, fetchHit());
    addV(I_ADDI, 0, 1, dec(Imm));
    addV(I_ADDI, 0, 1, mk(S_EXECI, 5'b00000, 0, 2, 1, ALU_FUNCT, 0, Imm, 0));
    addV(I_ADDI, 0, 1, mk(S_ALUWB, 5'b00001, 0, 0, 0, ALU_ADD, 0, Imm, 0));
    // jalr -> jal -> linked writeback
    addV(I_JALR, 0, 1, fetchHit());
    addV(I_JALR, 0, 1, dec(Imm));
    addV(I_JALR, 0, 1, mk(S_JALR,  5'b00000, 0, 2, 1, ALU_ADD, 0, Imm, 0));
    addV(I_JALR, 0, 1, mk(S_JAL,   5'b00010, 0, 1, 2, ALU_ADD, 0, Imm, 0));
    addV(I_JALR, 0, 1, mk(S_ALUWB, 5'b00001, 0, 1, 2, ALU_ADD, 2, Imm, 0));
    // illegal opcode: trap is sticky and silent even with ready high
    addV(I_ILL, 0, 1, fetchHit());
    addV(I_ILL, 0, 1, dec(Imm));
    addV(I_ILL, 0, 1, trapObs());
    addV(I_ILL, 0, 1, trapObs());
    addV(I_ILL, 1, 1, trapObs());

    @(posedge clk);
    #1;
    pulseReset("reset");

    for (int i = 0; i < vq.size(); i++)
      step(vq[i].instr, vq[i].zero, vq[i].ready, vq[i].exp, $sformatf("vec%0d", i));

    pulseReset("trapClear");

    // Unsupported branch funct3: no PC write, then trap
    step(I_BRX, 0, 1, settleObs(), "brxSettle");
    step(I_BRX, 0, 1, fetchHit(), "brxFetch");
    step(I_BRX, 0, 1, dec(Branch), "brxDecode");
    step(I_BRX, 1, 1, mk(S_BRANCH, 5'b00000, 0, 2, 0, ALU_SUB, 0, Branch, 0), "brxBranch");
    step(I_BRX, 1, 1, trapObs(), "brxTrap");
    pulseReset("brxReset");

    // Fetch timeout: MEM_TIMEOUT waiting cycles, then trap
    step(I_LW, 0, 0, settleObs(), "tmoSettle");
    for (int i = 0; i < MEM_TIMEOUT; i++)
      step(I_LW, 0, 0, fetchWait(), $sformatf("tmoWait%0d", i));
    step(I_LW, 0, 0, trapObs(), "tmoTrap");
    step(I_LW, 0, 1, trapObs(), "tmoSticky");
    pulseReset("tmoReset");

    // Reset asynchronously in the middle of a store
    step(I_SW, 0, 0, settleObs(), "mwSettle");
    step(I_SW, 0, 1, fetchHit(), "mwFetch");
    step(I_SW, 0, 1, dec(Store), "mwDecode");
    step(I_SW, 0, 1, mk(S_MEMADR, 5'b00000, 0, 2, 1, ALU_ADD, 0, Store, 0), "mwAdr");
    step(I_SW, 0, 0, memWr(), "mwWait");
    mem_ready = 1'b0;
    #1 check("mwHeld", memWr());
    #1 rst = 1'b1;
    #1 check("mwRstAsync", rstObs());
    @(posedge clk);
    #1 rst = 1'b0;
    step(I_SW, 0, 1, settleObs(), "postRstHold");
    step(I_SW, 0, 1, fetchHit(), "postRstFetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
